// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if: requester pixel/handshake bus and muxed VGA-side outputs of the plot arbiter.
interface plot_arbiter_if;
  logic [2:0] req, last, grant;
  logic [7:0] x0, x1, x2, x_out;
  logic [6:0] y0, y1, y2, y_out;
  logic [2:0] c0, c1, c2, colour_out;
  logic plot, frame_tick, busy;
  modport master (
    output req, last, x0, x1, x2, y0, y1, y2, c0, c1, c2,
    input  grant, x_out, y_out, colour_out, plot, frame_tick, busy
  );
  modport slave (
    input  req, last, x0, x1, x2, y0, y1, y2, c0, c1, c2,
    output grant, x_out, y_out, colour_out, plot, frame_tick, busy
  );
endinterface

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin burst arbiter of three sprite requesters onto one VGA pixel port, plus frame tick.
// Optional PLOT_ARBITER_CLIP_EN suppresses plot for pixels outside 160x120.
module plot_arbiter #(
  parameter int FRAME_DIV = 833333,
  parameter int MAX_BURST = 32
) (
  input logic clk,
  input logic resetn,
  plot_arbiter_if.slave bus
);
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam int FW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t state;
  logic [1:0] g, ptr, win;
  logic [2:0] grant_q;
  logic busy_q;
  logic [BW-1:0] cnt;
  logic [FW-1:0] fcnt;
  logic sel_req, sel_last, in_view, done;
  logic [7:0] sx;
  logic [6:0] sy;
  logic [2:0] sc;
  // search starts one past the previous winner
  assign win = ptr == 2'd0 ? (bus.req[1] ? 2'd1 : bus.req[2] ? 2'd2 : 2'd0)
             : ptr == 2'd1 ? (bus.req[2] ? 2'd2 : bus.req[0] ? 2'd0 : 2'd1)
             :               (bus.req[0] ? 2'd0 : bus.req[1] ? 2'd1 : 2'd2);
  assign sel_req  = g == 2'd0 ? bus.req[0]  : g == 2'd1 ? bus.req[1]  : bus.req[2];
  assign sel_last = g == 2'd0 ? bus.last[0] : g == 2'd1 ? bus.last[1] : bus.last[2];
  assign sx = g == 2'd0 ? bus.x0 : g == 2'd1 ? bus.x1 : bus.x2;
  assign sy = g == 2'd0 ? bus.y0 : g == 2'd1 ? bus.y1 : bus.y2;
  assign sc = g == 2'd0 ? bus.c0 : g == 2'd1 ? bus.c1 : bus.c2;
`ifdef PLOT_ARBITER_CLIP_EN
  assign in_view = sx <= 8'd159 && sy <= 7'd119;
`else
  assign in_view = 1'b1;
`endif
  assign done = !sel_req || sel_last || cnt == BW'(MAX_BURST - 1);
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.x_out      = busy_q ? sx : 8'd0;
  assign bus.y_out      = busy_q ? sy : 7'd0;
  assign bus.colour_out = busy_q ? sc : 3'd0;
  assign bus.plot       = busy_q && sel_req && in_view;
  assign bus.frame_tick = fcnt == FW'(FRAME_DIV - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ptr     <= 2'd2;
      g       <= 2'd0;
      cnt     <= '0;
      grant_q <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          state   <= BURST;
          g       <= win;
          grant_q <= 3'b001 << win;
          busy_q  <= 1'b1;
          cnt     <= '0;
        end
        BURST: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            state   <= GAP;
            ptr     <= g;
            grant_q <= 3'b000;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fcnt <= '0;
    else fcnt <= fcnt == FW'(FRAME_DIV - 1) ? '0 : fcnt + 1'b1;
  end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: sprite-requester model driving plot_arbiter, checking grant order, burst lengths, pixels and frame tick.
module tb_plot_arbiter;
  localparam int FD = 10, MB = 32;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  plot_arbiter_if bus();
  plot_arbiter #(.FRAME_DIV(FD), .MAX_BURST(MB)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int cmp = 0, bad = 0;
  int rem[3], len[3], pix[3], bx[3], by[3];
  logic [2:0] s_grant, s_c;
  logic s_plot;
  logic [7:0] s_x;
  logic [6:0] s_y;
  logic [2:0] tg[$];
  logic tp[$];
  logic [2:0] bg[$];
  int bp[$], bz[$];
  // each requester walks a sprite: pixel n of sprite i is a simple function of its random base
  function automatic logic [7:0] px(int i); return 8'((bx[i] + 5 * pix[i]) % 160); endfunction
  function automatic logic [6:0] py(int i); return 7'((by[i] + 3 * pix[i]) % 120); endfunction
  function automatic logic [2:0] pc(int i); return 3'((i + pix[i]) % 8); endfunction
  function automatic int rr(int p, logic [2:0] r);
    for (int k = 1; k <= 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction
  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      bus.req[i]  = rem[i] > 0;
      bus.last[i] = rem[i] == 1;
    end
    bus.x0 = px(0); bus.y0 = py(0); bus.c0 = pc(0);
    bus.x1 = px(1); bus.y1 = py(1); bus.c1 = pc(1);
    bus.x2 = px(2); bus.y2 = py(2); bus.c2 = pc(2);
  endtask
  task automatic sample();
    s_grant = bus.grant; s_plot = bus.plot;
    s_x = bus.x_out; s_y = bus.y_out; s_c = bus.colour_out;
  endtask
  task automatic advance();
    for (int i = 0; i < 3; i++)
      if (s_grant[i] && s_plot) begin
        pix[i]++;
        rem[i]--;
        if (rem[i] == 0 && len[i] > 0) rem[i] = len[i];
      end
    drive();
  endtask
  task automatic step();
    @(negedge clk);
    sample();
    tg.push_back(s_grant);
    tp.push_back(s_plot);
    @(posedge clk); #1;
    advance();
  endtask
  task automatic collect(int n);
    int z;
    tg.delete(); tp.delete();
    repeat (n) step();
    bg.delete(); bp.delete(); bz.delete();
    z = 0;
    for (int k = 0; k < tg.size(); k++) begin
      if (tg[k] == 3'b000) z++;
      else if (k == 0 || tg[k] != tg[k-1]) begin
        bg.push_back(tg[k]); bp.push_back(int'(tp[k])); bz.push_back(z); z = 0;
      end else bp[bp.size()-1] += int'(tp[k]);
    end
  endtask
  task automatic reset_dut();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; len[i] = 0; pix[i] = 0;
      bx[i] = int'($urandom_range(0, 159)); by[i] = int'($urandom_range(0, 119));
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin rem[i] = 5; len[i] = 0; pix[i] = 0; bx[i] = 170; by[i] = 10; end
    drive();
    repeat (3) begin
      @(negedge clk);
      cmp++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", bus.grant); end
      cmp++; if (bus.plot !== 1'b0) begin bad++; $display("FAIL reset_plot: got %b want 0", bus.plot); end
      cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      cmp++; if (bus.frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", bus.frame_tick); end
      cmp++; if ({bus.x_out, bus.y_out, bus.colour_out} !== 18'd0) begin bad++;
        $display("FAIL reset_pixel: got %h/%h/%h want 0/0/0", bus.x_out, bus.y_out, bus.colour_out); end
    end
  endtask
  task automatic test_single_burst();
    reset_dut();
    rem[0] = 16; drive();
    collect(22);
    cmp++; if (bg.size() != 1) begin bad++; $display("FAIL single_count: got %0d bursts want 1", bg.size()); end
    cmp++; if (bg[0] !== 3'b001) begin bad++; $display("FAIL single_grant: got %b want 001", bg[0]); end
    cmp++; if (bz[0] != 1) begin bad++; $display("FAIL single_latency: got %0d want 1", bz[0]); end
    cmp++; if (bp[0] != 16) begin bad++; $display("FAIL single_plots: got %0d want 16", bp[0]); end
    rem[0] = 2; rem[1] = 2; drive();
    collect(12);
    cmp++; if (bg[0] !== 3'b010) begin bad++; $display("FAIL single_ptr: got %b want 010", bg[0]); end
  endtask
  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < 3; i++) begin rem[i] = 4; len[i] = 4; end
    drive();
    collect(30);
    cmp++; if (bg.size() < 4) begin bad++; $display("FAIL rr_count: got %0d bursts want >=4", bg.size()); end
    for (int k = 0; k < 4; k++) begin
      cmp++; if (bg[k] !== 3'(1 << (k % 3))) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, bg[k], 3'(1 << (k % 3))); end
      cmp++; if (bp[k] != 4) begin bad++; $display("FAIL rr_plots%0d: got %0d want 4", k, bp[k]); end
      cmp++; if (bz[k] != (k == 0 ? 1 : 2)) begin bad++; $display("FAIL rr_gap%0d: got %0d want %0d", k, bz[k], k == 0 ? 1 : 2); end
    end
  endtask
  task automatic test_watchdog();
    reset_dut();
    rem[0] = 1000; drive();
    collect(40);
    cmp++; if (bg.size() < 2) begin bad++; $display("FAIL wd_count: got %0d bursts want >=2", bg.size()); end
    cmp++; if (bp[0] != MB) begin bad++; $display("FAIL wd_plots: got %0d want %0d", bp[0], MB); end
    cmp++; if (bg[1] !== 3'b001) begin bad++; $display("FAIL wd_regrant: got %b want 001", bg[1]); end
    cmp++; if (bz[1] != 2) begin bad++; $display("FAIL wd_gap: got %0d want 2", bz[1]); end
  endtask
  task automatic test_reset_mid_burst();
    reset_dut();
    rem[0] = 1000; rem[1] = 1000; drive();
    repeat (5) step();
    cmp++; if (bus.grant !== 3'b001) begin bad++; $display("FAIL mid_pre_grant: got %b want 001", bus.grant); end
    resetn = 1'b0;
    #1;
    cmp++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL mid_grant: got %b want 000", bus.grant); end
    cmp++; if (bus.plot !== 1'b0) begin bad++; $display("FAIL mid_plot: got %b want 0", bus.plot); end
    @(negedge clk);
    cmp++; if (bus.plot !== 1'b0) begin bad++; $display("FAIL mid_plot_hold: got %b want 0", bus.plot); end
    for (int i = 0; i < 3; i++) rem[i] = 0;
    rem[0] = 3; rem[1] = 3; drive();
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    collect(10);
    cmp++; if (bg[0] !== 3'b001) begin bad++; $display("FAIL mid_first: got %b want 001", bg[0]); end
  endtask
  task automatic test_frame_tick();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) rem[i] = 0;
    rem[0] = 1000; rem[2] = 1000; drive();
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    for (int n = 0; n < 35; n++) begin
      if (n > 0) @(negedge clk);
      cmp++; if (bus.frame_tick !== (n % FD == FD - 1)) begin bad++;
        $display("FAIL tick_c%0d: got %b want %b", n, bus.frame_tick, n % FD == FD - 1); end
    end
  endtask
  task automatic test_random();
    int mptr, cur, w, exp_len, plots;
    logic [2:0] prev_g, prev_req;
    reset_dut();
    mptr = 2; cur = 0; exp_len = 0; plots = 0; prev_g = 3'b000; prev_req = 3'b000;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      sample();
      if (s_grant != 3'b000) begin
        if (prev_g == 3'b000) begin
          w = rr(mptr, prev_req);
          cmp++; if (s_grant !== (w < 0 ? 3'b000 : 3'(1 << w))) begin bad++;
            $display("FAIL rand_winner@%0d: got %b want requester %0d", cyc, s_grant, w); end
          cur = w < 0 ? 0 : w;
          exp_len = rem[cur] < MB ? rem[cur] : MB;
          plots = 0;
        end
        plots += int'(s_plot);
        cmp++; if ({s_x, s_y, s_c} !== {px(cur), py(cur), pc(cur)}) begin bad++;
          $display("FAIL rand_pixel@%0d: got %h/%h/%h want %h/%h/%h", cyc, s_x, s_y, s_c, px(cur), py(cur), pc(cur)); end
      end else begin
        if (prev_g != 3'b000) begin
          cmp++; if (plots != exp_len) begin bad++; $display("FAIL rand_len@%0d: got %0d want %0d", cyc, plots, exp_len); end
          mptr = cur;
        end
        cmp++; if ({s_plot, s_x, s_y, s_c} !== 19'd0) begin bad++;
          $display("FAIL rand_idle@%0d: got plot %b pixel %h/%h/%h want all 0", cyc, s_plot, s_x, s_y, s_c); end
      end
      prev_g = s_grant;
      prev_req = bus.req;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
          rem[i] = int'($urandom_range(1, 45)); pix[i] = 0;
          bx[i] = int'($urandom_range(0, 159)); by[i] = int'($urandom_range(0, 119));
        end
      advance();
    end
  endtask
  task automatic test_clip();
    logic exp_plot;
`ifdef PLOT_ARBITER_CLIP_EN
    exp_plot = 1'b0;
`else
    exp_plot = 1'b1;
`endif
    reset_dut();
    bus.req = 3'b001; bus.last = 3'b000; bus.x0 = 8'd160; bus.y0 = 7'd50; bus.c0 = 3'd5;
    @(posedge clk); #1;
    @(negedge clk);
    cmp++; if (bus.grant !== 3'b001) begin bad++; $display("FAIL clip_grant: got %b want 001", bus.grant); end
    cmp++; if (bus.x_out !== 8'd160) begin bad++; $display("FAIL clip_x: got %0d want 160", bus.x_out); end
    cmp++; if (bus.plot !== exp_plot) begin bad++; $display("FAIL clip_plot: got %b want %b", bus.plot, exp_plot); end
    @(posedge clk); #1;
    @(negedge clk);
    cmp++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL clip_continue: got %b want 1", bus.busy); end
    bus.req = 3'b000;
  endtask
  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_watchdog();
    test_reset_mid_burst();
    test_frame_tick();
    test_random();
    test_clip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
